// File: rtl/load_store_unit.sv
// Load/store unit: sizes, aligns and lane-shifts core memory requests onto a single-beat bus.
// Optional memory watchdog is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int BE  = XLEN / 8;
   localparam int OFF = $clog2(BE);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]      state_reg, state_next;
   logic            we_reg;
   logic [2:0]      funct3_reg;
   logic [OFF-1:0]  off_reg;
   logic [XLEN-1:0] addr_reg, wdata_reg, rdata_reg;
   logic [BE-1:0]   be_reg;
   logic            err_reg;

   logic [1:0]      size;
   logic [OFF-1:0]  offset;
   logic [2:0]      align_mask;
   logic [BE-1:0]   size_mask;
   logic            illegal, misaligned, legal;
   logic [XLEN-1:0] shifted, load_data;
   logic            busy, timeout;

   assign size   = req_funct3[1:0];
   assign offset = req_addr[OFF-1:0];
   assign busy   = (state_reg == S_REQ) || (state_reg == S_WAIT);

   always_comb begin
      align_mask = 3'b000;
      size_mask  = BE'(8'h01);
      case (size)
         2'd0: begin align_mask = 3'b000; size_mask = BE'(8'h01); end
         2'd1: begin align_mask = 3'b001; size_mask = BE'(8'h03); end
         2'd2: begin align_mask = 3'b011; size_mask = BE'(8'h0F); end
         default: begin align_mask = 3'b111; size_mask = BE'(8'hFF); end
      endcase
   end

   always_comb begin
      illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
      if (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110))
         illegal = 1'b1;
   end

   assign misaligned = |(req_addr[2:0] & align_mask);
   assign legal      = !illegal && !misaligned;

   // Bring the addressed lane down to bit 0, then truncate and extend per size code.
   assign shifted = mem_rdata >> {off_reg, 3'b000};

   always_comb begin
      load_data = shifted;
      case (funct3_reg)
         3'b000:  load_data = XLEN'($signed(shifted[7:0]));
         3'b001:  load_data = XLEN'($signed(shifted[15:0]));
         3'b010:  load_data = XLEN'($signed(shifted[31:0]));
         3'b100:  load_data = XLEN'(shifted[7:0]);
         3'b101:  load_data = XLEN'(shifted[15:0]);
         3'b110:  load_data = XLEN'(shifted[31:0]);
         default: load_data = shifted;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt_reg;

   // The budget spans REQ and WAIT together; the count only restarts on a new bus request.
   assign timeout = busy && (tmo_cnt_reg >= CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tmo_cnt_reg <= '0;
      else if (state_reg == S_IDLE && req_valid && legal)
         tmo_cnt_reg <= '0;
      else if (busy)
         tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (req_valid) state_next = legal ? S_REQ : S_RESP;
         S_REQ: begin
            if (mem_gnt)      state_next = S_WAIT;
            else if (timeout) state_next = S_RESP;
         end
         S_WAIT: begin
            if (mem_rvalid)   state_next = S_RESP;
            else if (timeout) state_next = S_RESP;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         we_reg     <= 1'b0;
         funct3_reg <= 3'b000;
         off_reg    <= '0;
         addr_reg   <= '0;
         be_reg     <= '0;
         wdata_reg  <= '0;
         rdata_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  rdata_reg <= '0;
                  err_reg   <= !legal;
                  if (legal) begin
                     we_reg     <= req_we;
                     funct3_reg <= req_funct3;
                     off_reg    <= offset;
                     addr_reg   <= {req_addr[XLEN-1:OFF], {OFF{1'b0}}};
                     be_reg     <= size_mask << offset;
                     wdata_reg  <= req_wdata << {offset, 3'b000};
                  end
               end
            end
            S_REQ: begin
               if (!mem_gnt && timeout) begin
                  err_reg   <= 1'b1;
                  rdata_reg <= '0;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  err_reg   <= 1'b0;
                  rdata_reg <= we_reg ? '0 : load_data;
               end else if (timeout) begin
                  err_reg   <= 1'b1;
                  rdata_reg <= '0;
               end
            end
            default: begin
               err_reg   <= 1'b0;
               rdata_reg <= '0;
            end
         endcase
      end
   end

   assign req_ready  = (state_reg == S_IDLE);
   assign resp_valid = (state_reg == S_RESP);
   assign resp_err   = err_reg;
   assign resp_rdata = rdata_reg;
   assign mem_req    = (state_reg == S_REQ);
   assign mem_we     = we_reg && (state_reg == S_REQ);
   assign mem_addr   = addr_reg;
   assign mem_be     = be_reg;
   assign mem_wdata  = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 64-bit unit for main traffic, 32-bit unit for the XLEN=32 illegal case.
module tb_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_be;

   logic        req_valid_32, req_ready_32, req_we_32;
   logic [2:0]  req_funct3_32;
   logic [31:0] req_addr_32, req_wdata_32;
   logic        resp_valid_32, resp_err_32;
   logic [31:0] resp_rdata_32;
   logic        mem_req_32, mem_we_32, mem_gnt_32, mem_rvalid_32;
   logic [31:0] mem_addr_32, mem_wdata_32, mem_rdata_32;
   logic [3:0]  mem_be_32;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_32), .req_ready(req_ready_32), .req_we(req_we_32),
      .req_funct3(req_funct3_32), .req_addr(req_addr_32), .req_wdata(req_wdata_32),
      .resp_valid(resp_valid_32), .resp_rdata(resp_rdata_32), .resp_err(resp_err_32),
      .mem_req(mem_req_32), .mem_we(mem_we_32), .mem_addr(mem_addr_32), .mem_be(mem_be_32),
      .mem_wdata(mem_wdata_32), .mem_gnt(mem_gnt_32), .mem_rvalid(mem_rvalid_32), .mem_rdata(mem_rdata_32)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata);
      check({name, "/ready"}, req_ready, 1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      tick();
      req_valid  = 1'b0;
      req_addr   = 64'h0;
      req_wdata  = 64'h0;
   endtask

   // Legal access: REQ for gnt_wait+1 cycles, then rv_wait WAIT cycles, then one RESP cycle.
   task automatic txn_ok(input string name, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input int gnt_wait, input int rv_wait, input logic [63:0] rdata,
                         input logic [63:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
      issue(name, we, f3, addr, wdata);
      for (int c = 0; c <= gnt_wait; c++) begin
         check({name, "/mem_req"}, mem_req, 1);
         check({name, "/mem_addr"}, mem_addr, exp_addr);
         check({name, "/mem_be"}, mem_be, exp_be);
         check({name, "/mem_wdata"}, mem_wdata, exp_wdata);
         check({name, "/mem_we"}, mem_we, we);
         check({name, "/busy_ready"}, req_ready, 0);
         if (c == gnt_wait) begin
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = 64'hDEADBEEFDEADBEEF;
         end
         tick();
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      for (int c = 1; c <= rv_wait; c++) begin
         check({name, "/wait_req"}, mem_req, 0);
         check({name, "/wait_resp"}, resp_valid, 0);
         check({name, "/wait_ready"}, req_ready, 0);
         if (c == rv_wait) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
         end
         tick();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 64'h0;
      check({name, "/resp_valid"}, resp_valid, 1);
      check({name, "/resp_err"}, resp_err, 0);
      check({name, "/resp_rdata"}, resp_rdata, exp_rdata);
      tick();
      check({name, "/pulse_end"}, resp_valid, 0);
      check({name, "/idle_ready"}, req_ready, 1);
      $display("txn %s addr=0x%h be=0x%h rdata=0x%h", name, addr, exp_be, exp_rdata);
   endtask

   task automatic txn_err(input string name, input logic we, input logic [2:0] f3,
                          input logic [63:0] addr);
      issue(name, we, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
      check({name, "/resp_valid"}, resp_valid, 1);
      check({name, "/resp_err"}, resp_err, 1);
      check({name, "/resp_rdata"}, resp_rdata, 0);
      check({name, "/no_mem_req"}, mem_req, 0);
      tick();
      check({name, "/pulse_end"}, resp_valid, 0);
      check({name, "/no_mem_req2"}, mem_req, 0);
      check({name, "/idle_ready"}, req_ready, 1);
      $display("txn %s addr=0x%h error response", name, addr);
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 64'h0; req_wdata = 64'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
      req_valid_32 = 1'b0; req_we_32 = 1'b0; req_funct3_32 = 3'b000; req_addr_32 = 32'h0;
      req_wdata_32 = 32'h0; mem_gnt_32 = 1'b0; mem_rvalid_32 = 1'b0; mem_rdata_32 = 32'h0;

      tick();
      check("rst/ready", req_ready, 1);
      check("rst/resp_valid", resp_valid, 0);
      check("rst/mem_req", mem_req, 0);
      check("rst/mem_addr", mem_addr, 0);
      check("rst/mem_be", mem_be, 0);
      tick();
      reset = 1'b1;
      tick();

      // A stray response while idle must be ignored.
      mem_rvalid = 1'b1; mem_rdata = 64'h1;
      tick();
      mem_rvalid = 1'b0;
      check("idle_rvalid/resp", resp_valid, 0);
      check("idle_rvalid/ready", req_ready, 1);

      txn_ok("lb",  1'b0, 3'b000, 64'h80000003, 64'h0, 0, 1, 64'h0000000080000000,
             64'h80000000, 8'h08, 64'h0, 64'hFFFFFFFFFFFFFF80);
      txn_ok("lbu", 1'b0, 3'b100, 64'h80000003, 64'h0, 0, 1, 64'h0000000080000000,
             64'h80000000, 8'h08, 64'h0, 64'h0000000000000080);
      txn_ok("sh",  1'b1, 3'b001, 64'h80000006, 64'h1234, 0, 1, 64'hFFFFFFFFFFFFFFFF,
             64'h80000000, 8'hC0, 64'h1234000000000000, 64'h0);
      txn_ok("ld_slow", 1'b0, 3'b011, 64'h80000010, 64'h0, 3, 2, 64'h0123456789ABCDEF,
             64'h80000010, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
      txn_ok("lw",  1'b0, 3'b010, 64'h80000004, 64'h0, 1, 1, 64'h8765432100000000,
             64'h80000000, 8'hF0, 64'h0, 64'hFFFFFFFF87654321);
      txn_ok("lwu", 1'b0, 3'b110, 64'h80000004, 64'h0, 0, 1, 64'h8765432100000000,
             64'h80000000, 8'hF0, 64'h0, 64'h0000000087654321);
      txn_ok("lh",  1'b0, 3'b001, 64'h8000000A, 64'h0, 0, 1, 64'h00000000F00D0000,
             64'h80000008, 8'h0C, 64'h0, 64'hFFFFFFFFFFFFF00D);
      txn_ok("lhu", 1'b0, 3'b101, 64'h8000000A, 64'h0, 0, 1, 64'h00000000F00D0000,
             64'h80000008, 8'h0C, 64'h0, 64'h000000000000F00D);
      txn_ok("sw",  1'b1, 3'b010, 64'h80000004, 64'hAABBCCDD, 0, 1, 64'h0,
             64'h80000000, 8'hF0, 64'hAABBCCDD00000000, 64'h0);
      txn_ok("sb",  1'b1, 3'b000, 64'h80000001, 64'h5A, 0, 1, 64'h0,
             64'h80000000, 8'h02, 64'h0000000000005A00, 64'h0);
      txn_ok("sd",  1'b1, 3'b011, 64'h80000008, 64'h1122334455667788, 0, 1, 64'h0,
             64'h80000008, 8'hFF, 64'h1122334455667788, 64'h0);

      txn_err("lw_misaligned", 1'b0, 3'b010, 64'h80000002);
      txn_err("f3_111",        1'b0, 3'b111, 64'h80000000);
      txn_err("store_f3_100",  1'b1, 3'b100, 64'h80000000);
      txn_err("sd_misaligned", 1'b1, 3'b011, 64'h80000004);

      // 32-bit unit: a doubleword load is illegal there.
      check("x32_ld/ready", req_ready_32, 1);
      req_valid_32 = 1'b1; req_funct3_32 = 3'b011; req_addr_32 = 32'h80000000;
      tick();
      req_valid_32 = 1'b0;
      check("x32_ld/resp_valid", resp_valid_32, 1);
      check("x32_ld/resp_err", resp_err_32, 1);
      check("x32_ld/no_mem_req", mem_req_32, 0);
      tick();
      check("x32_ld/pulse_end", resp_valid_32, 0);
      check("x32_ld/idle_ready", req_ready_32, 1);
      $display("txn x32_ld addr=0x80000000 error response");

      // Reset while waiting for read data abandons the access.
      issue("rst_wait", 1'b1, 3'b011, 64'h80000020, 64'h1122334455667788);
      check("rst_wait/mem_req", mem_req, 1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("rst_wait/in_wait", mem_req, 0);
      #2 reset = 1'b0;
      #1;
      check("rst_wait/ready", req_ready, 1);
      check("rst_wait/mem_addr", mem_addr, 0);
      check("rst_wait/mem_be", mem_be, 0);
      check("rst_wait/mem_wdata", mem_wdata, 0);
      check("rst_wait/mem_we", mem_we, 0);
      check("rst_wait/resp_valid", resp_valid, 0);
      tick();
      reset = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 64'hCAFEF00DCAFEF00D;
      tick();
      mem_rvalid = 1'b0;
      check("rst_late/resp_valid", resp_valid, 0);
      check("rst_late/ready", req_ready, 1);
      tick();
      check("rst_late/resp_valid2", resp_valid, 0);
      $display("txn rst_wait abandoned by reset");

`ifdef LSU_TIMEOUT_EN
      issue("timeout", 1'b0, 3'b011, 64'h80000040, 64'h0);
      for (int c = 0; c < 8; c++) begin
         check("timeout/mem_req", mem_req, 1);
         check("timeout/no_resp", resp_valid, 0);
         tick();
      end
      check("timeout/resp_valid", resp_valid, 1);
      check("timeout/resp_err", resp_err, 1);
      check("timeout/mem_req_drop", mem_req, 0);
      tick();
      check("timeout/pulse_end", resp_valid, 0);
      check("timeout/ready", req_ready, 1);
      $display("txn timeout error after 8 cycles");
`else
      issue("no_timeout", 1'b0, 3'b011, 64'h80000040, 64'h0);
      for (int c = 0; c < 20; c++) begin
         check("no_timeout/mem_req", mem_req, 1);
         check("no_timeout/no_resp", resp_valid, 0);
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 64'h00000000000000AB;
      tick();
      mem_rvalid = 1'b0;
      check("no_timeout/resp_valid", resp_valid, 1);
      check("no_timeout/resp_err", resp_err, 0);
      check("no_timeout/resp_rdata", resp_rdata, 64'hAB);
      tick();
      check("no_timeout/ready", req_ready, 1);
      $display("txn no_timeout completed after long grant wait");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 64, SHALL set datapath/address width; only 32 and 64 are legal.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the memory watchdog limit (used only under LSU_TIMEOUT_EN).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core request strobe.
REQ-006 req_ready  output  1  LSU can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V size code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-009 req_addr  input  XLEN  byte address.
REQ-010 req_wdata  input  XLEN  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  access failed; valid with resp_valid.
REQ-014 mem_req / mem_we  output  1 each  bus request / write.
REQ-015 mem_addr  output  XLEN  req_addr with low log2(XLEN/8) bits cleared.
REQ-016 mem_be  output  XLEN/8  byte enables.
REQ-017 mem_wdata  output  XLEN  lane-shifted store data.
REQ-018 mem_gnt  input  1  bus accepted request.
REQ-019 mem_rvalid / mem_rdata  input  1 / XLEN  bus response (read data or write ack).

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept on req_valid&&req_ready; all request fields SHALL be registered at acceptance.
REQ-022 Illegal = funct3 111, or XLEN=32 with funct3 011/110, or store with funct3 100/101/110; misaligned = addr not a multiple of access size; either SHALL go IDLE->RESP with resp_err=1, no mem_req.
REQ-023 Legal: IDLE->REQ; mem_req=1 with addr/we/be/wdata held stable until mem_gnt; REQ->WAIT on mem_gnt.
REQ-024 WAIT->RESP on mem_rvalid; mem_rvalid SHALL be ignored in IDLE, REQ, RESP and in the grant cycle.
REQ-025 RESP lasts exactly one cycle (resp_valid=1), then IDLE; minimum latency accept->resp_valid = 3 cycles legal, 1 cycle error.
REQ-026 Lane offset o = addr[log2(XLEN/8)-1:0]; mem_be = size mask (1/3/F/FF) << o; mem_wdata = req_wdata << 8*o.
REQ-027 Load data = mem_rdata >> 8*o, truncated to size, sign-extended (b/h/w) or zero-extended (bu/hu/wu) to XLEN, registered on mem_rvalid.

Reset
REQ-028 reset low SHALL force state IDLE, req_ready=1, and resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata to 0 immediately.
REQ-029 Reset mid-transaction SHALL abandon it without response; late mem_rvalid after release SHALL be ignored.

Configuration
REQ-030 With LSU_TIMEOUT_EN defined, a counter SHALL clear on entering REQ, increment each REQ/WAIT cycle, and on TIMEOUT_CYCLES cycles without leaving REQ/WAIT SHALL go to RESP with resp_err=1 and drop mem_req.
REQ-031 Without LSU_TIMEOUT_EN, no counter SHALL exist and REQ/WAIT SHALL wait indefinitely.

Verification
REQ-032 XLEN=64, lb addr 0x80000003, mem_rdata 0x0000000080000000 -> resp_rdata 0xFFFFFFFFFFFFFF80, err 0; lbu same -> 0x0000000000000080.
REQ-033 sh addr 0x80000006 wdata 0x1234 -> mem_addr 0x80000000, mem_be 0xC0, mem_wdata 0x1234000000000000, mem_we 1; ack -> resp_rdata 0.
REQ-034 lw addr 0x80000002 -> resp_valid+resp_err one cycle after accept, mem_req never 1; XLEN=32 ld -> same.
REQ-035 ld, mem_gnt after 3 cycles, mem_rvalid 2 cycles after grant -> mem_req high 4 cycles with stable outputs, single resp_valid pulse, req_ready low throughout.
REQ-036 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_gnt held 0 -> mem_req high 8 cycles, then resp_err=1 one cycle, IDLE.
REQ-037 reset low in WAIT -> outputs zero same cycle; after release mem_rvalid=1 -> no resp_valid, req_ready=1.
